instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage: owns the PC, reads a local word-addressed
//  instruction memory, and emits {pc, instr} to decode over a valid/ready handshake.
//  Accepts branch/jump redirects from execute, supports decode back-pressure, and
//  halts on a configurable halt opcode. Sits between reset/boot control and decode.
// PARAMETERS
//  PC_W        32            PC / address width
//  IMEM_DEPTH  128           instruction words (power of 2); index = pc[log2(DEPTH)+1:2]
//  RESET_PC    32'h0         PC loaded on reset
//  HALT_INSTR  32'hFFFF_FFFF fetched word that stops sequential fetch
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  start         in   1      leave IDLE and begin fetching at RESET_PC
//  redir_valid   in   1      branch/jump taken this cycle
//  redir_addr    in   PC_W   redirect target
//  out_ready     in   1      decode accepts out_* this cycle
//  out_valid     out  1      out_pc/out_instr valid
//  out_pc        out  PC_W   PC of out_instr
//  out_instr     out  32     fetched instruction
//  out_misalign  out  1      out_pc[1:0]!=0 (instr fetched with low bits ignored)
//  halted        out  1      FSM in HALT
//  imem_we       in   1      memory load port (bench/boot), write enable
//  imem_waddr    in   PC_W   byte address of word to write
//  imem_wdata    in   32     word to write
// BEHAVIOUR
//  Reset: state=IDLE, fetch_pc=RESET_PC, out_valid=0, out_pc=0, out_instr=0,
//   out_misalign=0, halted=0; memory contents not reset. Reset mid-operation drops
//   any held output immediately (async).
//  FSM IDLE -> RUN on start; RUN -> HALT when a word == HALT_INSTR is loaded into
//   out_instr; HALT -> RUN on redir_valid; start ignored outside IDLE.
//  advance = !out_valid || out_ready.
//  RUN, redir_valid=1 (highest priority, overrides stall and squashes held output):
//   next cycle out_valid=1, out_pc=redir_addr, out_instr=imem[idx(redir_addr)],
//   fetch_pc=redir_addr+4.
//  RUN, advance, no redirect: out_pc=fetch_pc, out_instr=imem[idx(fetch_pc)],
//   out_valid=1, fetch_pc+=4.
//  RUN, !advance: all out_* and fetch_pc hold (stable while out_valid && !out_ready).
//  IDLE/HALT: no new fetch; held output still drains (out_valid clears on out_ready).
//  Latency: 1 cycle from fetch_pc/redirect to out_*; throughput 1 instr/cycle.
//  fetch_pc wraps modulo 2^PC_W; index uses low bits only (aliases past DEPTH).
//  Same-cycle imem write and read to same index: read returns OLD word.
//  out_misalign = redirect target[1:0]!=0; sequential fetch keeps same low bits.
// CONFIGURATION
//  IFU_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] (increments on each
//   out_valid&&out_ready) and perf_redirects[31:0] (increments on each redir_valid
//   in RUN/HALT); both reset to 0, saturate at all-ones.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package ifu_pkg: state enum {IFU_IDLE, IFU_RUN, IFU_HALT}, INSTR_W=32,
//   PC_STEP=4, idx() function.
//  Sub-module ifu_imem: DEPTH x 32 array, 1 async read port, 1 sync write port.
//  Top holds FSM, fetch_pc, output register, optional counters.
// TESTING
//  1 Load words 0x11,0x22,0x33 at 0,4,8; start, out_ready=1 -> out_pc 0,4,8 on
//    consecutive cycles, instr 0x11,0x22,0x33.
//  2 out_ready=0 for 3 cycles at out_pc=4 -> out_pc/out_instr held 4/0x22; release
//    -> next out_pc=8.
//  3 redir_valid with redir_addr=0x40 while stalled at pc 4 -> next cycle
//    out_pc=0x40, then 0x44; pc 4 never accepted.
//  4 HALT_INSTR at 0xC -> halted=1 after it is emitted, no pc 0x10; redirect to 0
//    -> RUN, out_pc=0.
//  5 rst_n low mid-stream -> out_valid=0, state IDLE immediately; fetch restarts at
//    RESET_PC only after start.
//  6 IFU_PERF_CNT_EN: 5 accepted fetches + 2 redirects -> perf_fetched=5,
//    perf_redirects=2; redirect to 0x42 -> out_misalign=1.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// Word index helper keeps the low address bits only, so addresses alias past the memory depth.
package ifu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_RUN  = 2'd1,
        IFU_HALT = 2'd2
    } ifu_state_e;

    // Byte address to word index: drop the two byte-offset bits, keep aw bits.
    function automatic int unsigned idx(input logic [63:0] addr, input int unsigned aw);
        logic [63:0] word;
        word = addr >> 2;
        return 32'(word & ((64'd1 << aw) - 64'd1));
    endfunction

endpackage

// File: rtl/ifu_imem.sv
// Local instruction memory: DEPTH x 32, asynchronous read, synchronous write, no reset.
// A read in the same cycle as a write to the same index sees the old word.
module ifu_imem
    import ifu_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads ifu_imem and presents {pc, instr} to decode; IFU_PERF_CNT_EN adds perf counters.
// One cycle from fetch_pc/redirect to out_*; outputs hold while out_valid && !out_ready, redirects override the stall.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                 PC_W       = 32,
    parameter int                 IMEM_DEPTH = 128,
    parameter logic [PC_W-1:0]    RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               redir_valid,
    input  logic [PC_W-1:0]    redir_addr,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_misalign,
    output logic               halted,
    input  logic               imem_we,
    input  logic [PC_W-1:0]    imem_waddr,
    input  logic [INSTR_W-1:0] imem_wdata
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_redirects
`endif
);

    localparam int AW = $clog2(IMEM_DEPTH);

    ifu_state_e         state;
    ifu_state_e         state_nxt;
    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    rd_addr;
    logic [AW-1:0]      rd_idx;
    logic [AW-1:0]      wr_idx;
    logic [INSTR_W-1:0] rd_data;
    logic               advance;
    logic               ld_redir;
    logic               ld_seq;
    logic               ld;

    // Redirects are honoured in RUN and HALT; IDLE waits for start only.
    always_comb begin
        advance  = !out_valid || out_ready;
        ld_redir = redir_valid && (state != IFU_IDLE);
        ld_seq   = (state == IFU_RUN) && !redir_valid && advance;
        ld       = ld_redir || ld_seq;
        rd_addr  = ld_redir ? redir_addr : fetch_pc;
        rd_idx   = AW'(idx(64'(rd_addr), AW));
        wr_idx   = AW'(idx(64'(imem_waddr), AW));
    end

    ifu_imem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (wr_idx),
        .wdata (imem_wdata),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IFU_IDLE: begin
                if (start) begin
                    state_nxt = IFU_RUN;
                end
            end
            IFU_RUN, IFU_HALT: begin
                if (ld) begin
                    state_nxt = (rd_data == HALT_INSTR) ? IFU_HALT : IFU_RUN;
                end
            end
            default: state_nxt = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IFU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign halted = (state == IFU_HALT);

    // Output register: load on fetch, drain on acceptance, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_instr    <= '0;
            out_misalign <= 1'b0;
        end else if (ld) begin
            fetch_pc     <= rd_addr + PC_W'(PC_STEP);
            out_valid    <= 1'b1;
            out_pc       <= rd_addr;
            out_instr    <= rd_data;
            out_misalign <= (rd_addr[1:0] != 2'b00);
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else begin
            if (out_valid && out_ready && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (ld_redir && (perf_redirects != '1)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected {pc, instr} pairs are queued as stimulus is driven
// and popped whenever decode accepts an output.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;
    logic        halted;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] tb_mem [128];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          n_redir = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .redir_valid  (redir_valid),
        .redir_addr   (redir_addr),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_misalign (out_misalign),
        .halted       (halted),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects)
`endif
    );

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        return tb_mem[a[8:2]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        q.push_back('{pc: pc, instr: exp_instr(pc)});
    endtask

    task automatic push_raw(input logic [31:0] pc, input logic [31:0] instr);
        q.push_back('{pc: pc, instr: instr});
    endtask

    // Sample the handshake on the falling edge, then advance to just past the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_acc++;
            n_cmp++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected: observed accepted pc %h expected none", out_pc);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_instr", out_instr, e.instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic redir_tick(input logic [31:0] a);
        redir_valid = 1'b1;
        redir_addr  = a;
        n_redir++;
        tick();
        redir_valid = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        tick();
        imem_we    = 1'b0;
        tb_mem[a[8:2]] = d;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; redir_valid = 1'b0; redir_addr = '0;
        out_ready = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        for (int i = 0; i < 128; i++) tb_mem[i] = '0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_misalign", 32'(out_misalign), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_redirects", perf_redirects, 32'd0);
`endif
        rst_n = 1'b1;

        load_word(32'h000, 32'h11);
        load_word(32'h004, 32'h22);
        load_word(32'h008, 32'h33);
        load_word(32'h00C, 32'hFFFF_FFFF);
        load_word(32'h040, 32'hA0);
        load_word(32'h044, 32'hA4);
        load_word(32'h048, 32'hA8);
        load_word(32'h1FC, 32'h77);

        out_ready = 1'b1;
        tick();
        tick();
        chk("idle_no_fetch", 32'(out_valid), 32'd0);

        // Sequential stream from RESET_PC up to the halt word.
        start = 1'b1;
        tick();
        start = 1'b0;
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        repeat (4) tick();
        chk("halt_on_word", 32'(halted), 32'd1);
        chk("halt_word_pc", out_pc, 32'hC);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("halt_ignores_start", 32'(halted), 32'd1);
        chk("halt_no_fetch", 32'(out_valid), 32'd0);
        chk("halt_drained", 32'(q.size()), 32'd0);

        // Redirect out of HALT.
        redir_tick(32'h0);
        chk("halt_redir_run", 32'(halted), 32'd0);
        chk("halt_redir_pc", out_pc, 32'h0);
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        repeat (5) tick();
        chk("rehalt", 32'(halted), 32'd1);
        chk("rehalt_drained", 32'(q.size()), 32'd0);

        // Back-pressure at pc 4.
        redir_tick(32'h0);
        push(32'h0);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", out_pc, 32'h4);
            chk("stall_instr", out_instr, 32'h22);
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        push(32'h4);
        tick();
        chk("release_pc", out_pc, 32'h8);
        chk("release_instr", out_instr, 32'h33);
        out_ready = 1'b0;

        // Redirect squashes a held output.
        redir_tick(32'h0);
        out_ready = 1'b1;
        push(32'h0);
        tick();
        out_ready = 1'b0;
        tick();
        chk("stall_at_4", out_pc, 32'h4);
        redir_tick(32'h40);
        chk("redir_pc", out_pc, 32'h40);
        chk("redir_instr", out_instr, 32'hA0);
        out_ready = 1'b1;
        push(32'h40);
        tick();
        chk("redir_seq_pc", out_pc, 32'h44);
        push(32'h44);
        redir_tick(32'h42);
        chk("misalign_pc", out_pc, 32'h42);
        chk("misalign_flag", 32'(out_misalign), 32'd1);
        chk("misalign_instr", out_instr, 32'hA0);
        push(32'h42);
        tick();
        chk("misalign_seq_pc", out_pc, 32'h46);
        chk("misalign_seq_flag", 32'(out_misalign), 32'd1);
        chk("misalign_seq_instr", out_instr, 32'hA4);
        out_ready = 1'b0;
        tick();
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'(n_acc));
        chk("perf_redirects", perf_redirects, 32'(n_redir));
`endif

        // Asynchronous reset while an output is held.
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_misalign", 32'(out_misalign), 32'd0);
`ifdef IFU_PERF_CNT_EN
        chk("arst_perf_fetched", perf_fetched, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("arst_wait_start", 32'(out_valid), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        push(32'h0);
        tick();
        chk("restart_pc", out_pc, 32'h0);
        chk("restart_valid", 32'(out_valid), 32'd1);
        push(32'h4);
        tick();
        out_ready = 1'b0;
        tick();

        // Write and read of the same index in one cycle returns the old word.
        out_ready  = 1'b1;
        imem_we    = 1'b1;
        imem_waddr = 32'h8;
        imem_wdata = 32'h99;
        tick();
        imem_we = 1'b0;
        tb_mem[2] = 32'h99;
        chk("rw_old_pc", out_pc, 32'h8);
        chk("rw_old_instr", out_instr, 32'h33);
        push_raw(32'h8, 32'h33);
        redir_tick(32'h8);
        chk("rw_new_instr", out_instr, 32'h99);

        // Index aliasing and PC wrap.
        push(32'h8);
        redir_tick(32'h200);
        chk("alias_pc", out_pc, 32'h200);
        chk("alias_instr", out_instr, 32'h11);
        push(32'h200);
        redir_tick(32'hFFFF_FFFC);
        chk("top_pc", out_pc, 32'hFFFF_FFFC);
        chk("top_instr", out_instr, 32'h77);
        push(32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", out_pc, 32'h0);
        chk("wrap_instr", out_instr, 32'h11);
        out_ready = 1'b0;
        tick();
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
